// File: rtl/alu_pkg.sv
// Shared definitions for the add/sub control unit command path:
// mode encodings, issuer FSM state encoding and a saturating adder.
package alu_pkg;

    localparam logic [1:0] MODO_NOP = 2'b00;
    localparam logic [1:0] MODO_ADD = 2'b01;
    localparam logic [1:0] MODO_SUB = 2'b10;
    localparam logic [1:0] MODO_CLR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        PAUSE = 2'd2
    } issuer_state_t;

    // 16-bit add that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/op_fifo.sv
// Request buffer for the issuer: DEPTH entries of DW bits with exact
// occupancy. Reads come only from stored entries (no fall-through), a push
// into a full buffer is dropped even if a pop happens in the same cycle, and
// flush empties the buffer with priority over push and pop.
module op_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DW-1:0]            pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Command stage for the 4-bit add/sub unit: buffers requests, issues one per
// cycle as registered enb/modo/A/B and flags res_valid when Q/RCO hold the
// result. Optional per-mode statistics counters with ISSUER_STATS_EN.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_modo,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic                     hold,
    input  logic                     flush,
    output logic                     enb,
    output logic [1:0]               modo,
    output logic [WIDTH-1:0]         A,
    output logic [WIDTH-1:0]         B,
    output logic                     res_valid,
    output logic [$clog2(DEPTH):0]   level
`ifdef ISSUER_STATS_EN
    ,
    output logic [15:0]              n_add,
    output logic [15:0]              n_sub,
    output logic [15:0]              n_clr,
    output logic [15:0]              n_drop
`endif
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int DW = 2 + 2 * WIDTH;

    issuer_state_t   state;
    issuer_state_t   next_state;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [DW-1:0]   pop_data;
    logic [1:0]      entry_modo;
    logic [WIDTH-1:0] entry_a;
    logic [WIDTH-1:0] entry_b;

    assign cmd_ready  = !reset && !full && !flush;
    assign push       = cmd_valid && cmd_ready;
    assign entry_modo = pop_data[DW-1 -: 2];
    assign entry_a    = pop_data[2*WIDTH-1 -: WIDTH];
    assign entry_b    = pop_data[WIDTH-1:0];

    op_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({cmd_modo, cmd_a, cmd_b}),
        .pop       (pop),
        .flush     (flush),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // State register for the issue FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state and pop decision; IDLE pops on its way out so a fresh request issues one edge after accept
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty && !hold) begin
                        pop        = 1'b1;
                        next_state = ISSUE;
                    end
                end
                ISSUE: begin
                    if (hold) begin
                        next_state = PAUSE;
                    end else if (empty) begin
                        next_state = IDLE;
                    end else begin
                        pop = 1'b1;
                        if (level == LW'(1) && !push) next_state = IDLE;
                    end
                end
                PAUSE: begin
                    if (!hold) next_state = empty ? IDLE : ISSUE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Issue registers and the one-cycle res_valid delay behind enb
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enb       <= 1'b0;
            modo      <= MODO_NOP;
            A         <= '0;
            B         <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= enb;
            if (pop && entry_modo != MODO_NOP) begin
                enb  <= 1'b1;
                modo <= entry_modo;
                A    <= entry_a;
                B    <= entry_b;
            end else begin
                enb  <= 1'b0;
            end
        end
    end

`ifdef ISSUER_STATS_EN
    // Saturating counters: issued ops per mode, and entries lost to flush or no-ops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_add  <= '0;
            n_sub  <= '0;
            n_clr  <= '0;
            n_drop <= '0;
        end else if (flush) begin
            n_drop <= sat_add16(n_drop, 16'(level));
        end else if (pop) begin
            case (entry_modo)
                MODO_ADD: n_add  <= sat_add16(n_add, 16'd1);
                MODO_SUB: n_sub  <= sat_add16(n_sub, 16'd1);
                MODO_CLR: n_clr  <= sat_add16(n_clr, 16'd1);
                default:  n_drop <= sat_add16(n_drop, 16'd1);
            endcase
        end
    end
`endif

endmodule
